// File: rtl/genesis_lpf_pkg.sv
// Shared types and coefficient table for the Genesis multi-channel audio low-pass.
// Provides lpf_mode_t, coef_t, lpf_coef_s, lpf_coef() and the 106 kHz divider constant.
package genesis_lpf_pkg;

  localparam int FS_DIV_106K = 504;
  localparam int LPF_COEF_W  = 18;

  typedef enum logic [1:0] {
    M1      = 2'b00,
    M2      = 2'b01,
    MINIMAL = 2'b10,
    BYPASS  = 2'b11
  } lpf_mode_t;

  typedef logic signed [LPF_COEF_W-1:0] coef_t;

  typedef struct packed {
    coef_t a2;
    coef_t b1;
    coef_t b2;
  } lpf_coef_s;

  function automatic lpf_coef_s lpf_coef(lpf_mode_t m);
    lpf_coef_s c;
    c.a2 = coef_t'(-32768);
    c.b1 = coef_t'(0);
    c.b2 = coef_t'(0);
    unique case (m)
      M1: begin
        c.a2 = coef_t'(-27504);
        c.b1 = coef_t'(10528);
        c.b2 = coef_t'(-5264);
      end
      M2: begin
        c.a2 = coef_t'(-26328);
        c.b1 = coef_t'(12888);
        c.b2 = coef_t'(-6440);
      end
      MINIMAL: begin
        c.a2 = coef_t'(-19088);
        c.b1 = coef_t'(6840);
        c.b2 = coef_t'(6840);
      end
      BYPASS: begin
        c.a2 = coef_t'(-32768);
        c.b1 = coef_t'(0);
        c.b2 = coef_t'(0);
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/genesis_lpf_mc_mac.sv
// Shared multiply-accumulate for the low-pass: one signed coef x sample product per cycle.
// Ports: clk, reset, en/clr/sub controls, coef, samp in; registered acc out.
module lpf_mac #(
  parameter int WIDTH  = 16,
  parameter int COEF_W = 18,
  parameter int ACC_W  = WIDTH + COEF_W + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     sub,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [WIDTH-1:0]  samp,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PW = WIDTH + COEF_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_q;

  always_comb begin
    prod   = PW'(coef) * PW'(samp);
    prod_x = ACC_W'(prod);
    acc_d  = acc_q;
    if (en) begin
      if (clr)
        acc_d = prod_x;
      else if (sub)
        acc_d = acc_q - prod_x;
      else
        acc_d = acc_q + prod_x;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/genesis_lpf_mc.sv
// Multi-channel 1st-order IIR low-pass, one time-shared MAC, shadowed mode, saturating out.
// Ports: clk, reset (sync high), lpf_mode, packed in/out per channel, out_stb when all updated.
module genesis_lpf_mc
  import genesis_lpf_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int COEF_W   = 18,
  parameter int FRAC     = 15,
  parameter int DIV      = FS_DIV_106K
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                lpf_mode,
  input  logic [CHANNELS*WIDTH-1:0] in,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic                      out_stb
);

  localparam int ACC_W = WIDTH + COEF_W + 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MUL_B1 = 3'd1;
  localparam logic [2:0] S_MUL_B2 = 3'd2;
  localparam logic [2:0] S_MUL_A2 = 3'd3;
  localparam logic [2:0] S_STORE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_ch
    $error("genesis_lpf_mc: CHANNELS must be 1..8");
  end
  if (DIV < 4*CHANNELS + 2) begin : g_bad_div
    $error("genesis_lpf_mc: DIV too small for CHANNELS");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [2:0]       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  lpf_mode_t        mode_q, mode_d;
  logic             out_stb_q, out_stb_d;

  logic signed [WIDTH-1:0] xin_q [CHANNELS];
  logic signed [WIDTH-1:0] xin_d [CHANNELS];
  logic signed [WIDTH-1:0] x1_q  [CHANNELS];
  logic signed [WIDTH-1:0] x1_d  [CHANNELS];
  logic signed [WIDTH-1:0] y1_q  [CHANNELS];
  logic signed [WIDTH-1:0] y1_d  [CHANNELS];
  logic signed [WIDTH-1:0] out_q [CHANNELS];
  logic signed [WIDTH-1:0] out_d [CHANNELS];

  lpf_coef_s               cf;
  logic                    mac_en, mac_clr, mac_sub;
  logic signed [COEF_W-1:0] mac_coef;
  logic signed [WIDTH-1:0]  mac_samp;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [WIDTH-1:0]  y_sat;
  logic signed [WIDTH-1:0]  y_new;

  lpf_mac #(
    .WIDTH (WIDTH),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .en   (mac_en),
    .clr  (mac_clr),
    .sub  (mac_sub),
    .coef (mac_coef),
    .samp (mac_samp),
    .acc  (acc)
  );

  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV-1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Floor shift, then clamp when the bits above the sign do not agree.
  always_comb begin
    acc_sh = acc >>> FRAC;
    if (&acc_sh[ACC_W-1:WIDTH-1] || ~|acc_sh[ACC_W-1:WIDTH-1])
      y_sat = acc_sh[WIDTH-1:0];
    else if (acc_sh[ACC_W-1])
      y_sat = {1'b1, {(WIDTH-1){1'b0}}};
    else
      y_sat = {1'b0, {(WIDTH-1){1'b1}}};
    // Bypass passes the sample straight through; the MAC result is unused.
    y_new = (mode_q == BYPASS) ? xin_q[ch_q] : y_sat;
  end

  always_comb begin
    cf       = lpf_coef(mode_q);
    state_d  = state_q;
    ch_d     = ch_q;
    mode_d   = mode_q;
    xin_d    = xin_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    out_d    = out_q;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    mac_sub  = 1'b0;
    mac_coef = '0;
    mac_samp = '0;

    if (tick) begin
      mode_d = lpf_mode_t'(lpf_mode);
      for (int c = 0; c < CHANNELS; c++)
        xin_d[c] = in[c*WIDTH +: WIDTH];
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_MUL_B1;
          ch_d    = '0;
        end
      end
      S_MUL_B1: begin
        mac_en   = 1'b1;
        mac_clr  = 1'b1;
        mac_coef = COEF_W'(cf.b1);
        mac_samp = xin_q[ch_q];
        state_d  = S_MUL_B2;
      end
      S_MUL_B2: begin
        mac_en   = 1'b1;
        mac_coef = COEF_W'(cf.b2);
        mac_samp = x1_q[ch_q];
        state_d  = S_MUL_A2;
      end
      S_MUL_A2: begin
        mac_en   = 1'b1;
        mac_sub  = 1'b1;
        mac_coef = COEF_W'(cf.a2);
        mac_samp = y1_q[ch_q];
        state_d  = S_STORE;
      end
      S_STORE: begin
        out_d[ch_q] = y_new;
        x1_d[ch_q]  = xin_q[ch_q];
        y1_d[ch_q]  = y_new;
        if (ch_q == CH_W'(CHANNELS-1)) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = S_MUL_B1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    out_stb_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      ch_q      <= '0;
      mode_q    <= M1;
      out_stb_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        xin_q[c] <= '0;
        x1_q[c]  <= '0;
        y1_q[c]  <= '0;
        out_q[c] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      ch_q      <= ch_d;
      mode_q    <= mode_d;
      out_stb_q <= out_stb_d;
      xin_q     <= xin_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      out_q     <= out_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign out[g*WIDTH +: WIDTH] = out_q[g];
  end

  assign out_stb = out_stb_q;

endmodule

// File: tb/tb_genesis_lpf_mc.sv
// Bench for genesis_lpf_mc: 4 channels, DIV=18, scoreboard against an integer model.
// Ports driven: clk, reset, lpf_mode, in; observed: out, out_stb.
module tb_genesis_lpf_mc;

  localparam int CH  = 4;
  localparam int W   = 16;
  localparam int DIV = 18;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      lpf_mode = 2'b00;
  logic [CH*W-1:0] in_v = '0;
  logic [CH*W-1:0] out_v;
  logic            out_stb;

  always #5 clk = ~clk;

  genesis_lpf_mc #(
    .CHANNELS(CH),
    .WIDTH   (W),
    .COEF_W  (18),
    .FRAC    (15),
    .DIV     (DIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .lpf_mode(lpf_mode),
    .in      (in_v),
    .out     (out_v),
    .out_stb (out_stb)
  );

  typedef struct packed {
    logic [CH*W-1:0] y;
    logic [31:0]     tick_e;
  } exp_t;

  exp_t            sb[$];
  int              ch0_log[$];
  int              n_chk = 0;
  int              n_fail = 0;
  int              e = 0;
  int              last_stb_e = -1;
  bit              in_rst = 1'b1;
  logic [CH*W-1:0] last_exp = '0;
  int              x1m[CH];
  int              y1m[CH];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [CH*W-1:0] v, input int c);
    logic signed [W-1:0] s;
    s = v[c*W +: W];
    return int'(s);
  endfunction

  function automatic logic [CH*W-1:0] pk(input int a, input int b,
                                         input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic int model_y(input logic [1:0] m, input int x,
                                 input int x1, input int y1);
    longint a2, b1, b2, acc, q;
    case (m)
      2'b00: begin a2 = -27504; b1 = 10528; b2 = -5264; end
      2'b01: begin a2 = -26328; b1 = 12888; b2 = -6440; end
      2'b10: begin a2 = -19088; b1 = 6840;  b2 = 6840;  end
      default: return x;
    endcase
    acc = b1*x + b2*x1 - a2*y1;
    q = acc >>> 15;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  task automatic monitor();
    bit   exp_stb;
    exp_t it;
    if (in_rst) return;
    exp_stb = (e > DIV) && (e % DIV == 4*CH);
    if (out_stb || exp_stb) chk("stb", longint'(out_stb), longint'(exp_stb));
    if (out_stb) begin
      if (last_stb_e >= 0) chk("stb_period", e - last_stb_e, DIV);
      last_stb_e = e;
      chk("sb_nonempty", longint'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        chk("latency", e - int'(it.tick_e) + 1, 4*CH + 1);
        for (int c = 0; c < CH; c++)
          chk($sformatf("out_ch%0d", c), sx(out_v, c), sx(it.y, c));
        last_exp = it.y;
      end
      ch0_log.push_back(sx(out_v, 0));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    e++;
    monitor();
  endtask

  task automatic garbage();
    in_v     = {$urandom, $urandom};
    lpf_mode = 2'($urandom_range(0, 3));
  endtask

  task automatic do_tick(input logic [1:0] m, input logic [CH*W-1:0] xv);
    exp_t it;
    int   xc, y;
    forever begin
      cycle();
      if ((e + 1) % DIV == 0) break;
      garbage();
    end
    if (sb.size() == 0) chk("hold", longint'(out_v), longint'(last_exp));
    lpf_mode = m;
    in_v     = xv;
    it.y     = '0;
    for (int c = 0; c < CH; c++) begin
      xc = sx(xv, c);
      y  = model_y(m, xc, x1m[c], y1m[c]);
      x1m[c] = xc;
      y1m[c] = y;
      it.y[c*W +: W] = W'(y);
    end
    it.tick_e = 32'(e + 1);
    sb.push_back(it);
  endtask

  task automatic wait_stb();
    bit seen = 1'b0;
    for (int i = 0; i < DIV; i++) begin
      cycle();
      if (out_stb) begin
        seen = 1'b1;
        break;
      end
      if ((e + 1) % DIV == 0) break;
      garbage();
    end
    chk("stb_wait", longint'(seen), 1);
  endtask

  task automatic clear_model();
    sb.delete();
    for (int c = 0; c < CH; c++) begin
      x1m[c] = 0;
      y1m[c] = 0;
    end
    last_exp   = '0;
    last_stb_e = -1;
  endtask

  task automatic do_reset(input int ncyc);
    reset  = 1'b1;
    in_rst = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      cycle();
      chk("rst_out", longint'(out_v), 0);
      chk("rst_stb", longint'(out_stb), 0);
    end
    clear_model();
    reset  = 1'b0;
    e      = 0;
    in_rst = 1'b0;
  endtask

  initial begin
    bit mono;
    int v;

    do_reset(3);

    // Step on ch0 in mode 00.
    ch0_log.delete();
    for (int t = 0; t < 200; t++)
      do_tick(2'b00, pk(8192, int'($urandom_range(0, 65535)) - 32768,
                        int'($urandom_range(0, 65535)) - 32768, 100));
    wait_stb();
    chk("step_cnt", ch0_log.size(), 200);
    if (ch0_log.size() >= 200) begin
      chk("step_first", ch0_log[0], 2632);
      mono = 1'b1;
      for (int i = 1; i < 200; i++)
        if (ch0_log[i] < ch0_log[i-1]) mono = 1'b0;
      chk("step_mono", longint'(mono), 1);
      // Floor rounding leaves a dead band of up to 6 LSB below the target.
      v = ch0_log[199] - 8192;
      chk("step_settle", longint'(v <= 2 && v >= -8), 1);
    end

    // Reset in the middle of a sequence.
    do_tick(2'b00, pk(1000, 2000, 3000, 4000));
    for (int i = 0; i < 5; i++) begin
      cycle();
      garbage();
    end
    do_reset(3);
    chk("post_rst_out", longint'(out_v), 0);

    // Nyquist rejection in mode 10.
    ch0_log.delete();
    for (int t = 0; t < 30; t++)
      do_tick(2'b10, pk((t % 2 == 0) ? 16384 : -16384, 500, -500, 7));
    wait_stb();
    chk("nyq_cnt", ch0_log.size(), 30);
    mono = 1'b1;
    for (int i = 20; i < ch0_log.size(); i++)
      if (ch0_log[i] >= 1024 || ch0_log[i] <= -1024) mono = 1'b0;
    chk("nyq_reject", longint'(mono), 1);

    // Bypass: exact pass-through, history still tracked by the model.
    do_tick(2'b11, pk(1000, -12345, 32767, -32768));
    wait_stb();
    chk("byp_ch1", sx(out_v, 1), -12345);
    chk("byp_ch0", sx(out_v, 0), 1000);
    chk("byp_ch3", sx(out_v, 3), -32768);

    // Mode 00 then 01 with retained history; mode wiggles between ticks.
    for (int t = 0; t < 6; t++)
      do_tick(2'b00, pk(20000, -20000, 5000, -5000));
    for (int t = 0; t < 6; t++)
      do_tick(2'b01, pk(20000, -20000, 5000, -5000));

    // Full-scale steps to exercise saturation.
    for (int t = 0; t < 40; t++)
      do_tick(2'($urandom_range(0, 2)),
              (t % 2 == 0) ? pk(32767, -32768, 32767, -32768)
                           : pk(-32768, 32767, -32768, 32767));

    // Random traffic, random modes.
    for (int t = 0; t < 1000; t++)
      do_tick(2'($urandom_range(0, 3)), {$urandom, $urandom});
    wait_stb();
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
